// File: rtl/chrono_pkg.sv
// Shared chronometer definitions: replay FSM states and ring-address helpers.
package chrono_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } replay_state_e;

  function automatic int unsigned depth_of(input int unsigned addr_bits);
    return 32'd1 << addr_bits;
  endfunction

  function automatic int unsigned mod_inc(input int unsigned value, input int unsigned addr_bits);
    return (value + 32'd1) & (depth_of(addr_bits) - 32'd1);
  endfunction

endpackage

// File: rtl/lap_ring_ptr.sv
// Circular-buffer bookkeeping for the lap memory: head/tail/count and the
// full/empty/overflow flags. A write into a full ring drops the oldest entry.
module lap_ring_ptr
  import chrono_pkg::*;
#(
  parameter int RAM_ADDR_BITS = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  output logic [RAM_ADDR_BITS-1:0] head,
  output logic [RAM_ADDR_BITS-1:0] tail,
  output logic [RAM_ADDR_BITS:0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic                     overwrite
);

  typedef logic [RAM_ADDR_BITS-1:0] addr_t;
  typedef logic [RAM_ADDR_BITS:0]   cnt_t;

  localparam cnt_t DEPTH = cnt_t'(depth_of(RAM_ADDR_BITS));

  addr_t head_inc;
  addr_t tail_inc;

  assign head_inc  = addr_t'(mod_inc(32'(head), RAM_ADDR_BITS));
  assign tail_inc  = addr_t'(mod_inc(32'(tail), RAM_ADDR_BITS));
  assign full      = (count == DEPTH);
  assign empty     = (count == '0);
  assign overwrite = push && full && !clear;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (push) begin
      head <= head_inc;
      if (full) begin
        tail     <= tail_inc;
        overflow <= 1'b1;
      end else begin
        count <= count + cnt_t'(1);
      end
    end
  end

endmodule

// File: rtl/lap_log_ctrl.sv
// Lap-time logger: records strobed timestamps into the lap memory as a ring and
// replays them one per recall through the memory's one-cycle registered read.
module lap_log_ctrl
  import chrono_pkg::*;
#(
  parameter int RAM_WIDTH     = 16,
  parameter int RAM_ADDR_BITS = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     lap_strobe,
  input  logic [RAM_WIDTH-1:0]     lap_time,
  input  logic                     clear,
  input  logic                     recall_next,
  output logic [RAM_ADDR_BITS-1:0] wr_addr,
  output logic [RAM_WIDTH-1:0]     wr_data,
  output logic                     write_enable,
  output logic [RAM_ADDR_BITS-1:0] rd_addr,
  input  logic [RAM_WIDTH-1:0]     rd_data,
  output logic [RAM_WIDTH-1:0]     disp_data,
  output logic [RAM_ADDR_BITS-1:0] disp_addr,
  output logic                     disp_valid,
  output logic                     busy,
  output logic [RAM_ADDR_BITS:0]   lap_count,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow
);

  typedef logic [RAM_ADDR_BITS-1:0] addr_t;

  replay_state_e state;
  addr_t         head;
  addr_t         tail;
  addr_t         cursor;
  addr_t         cursor_next;
  addr_t         head_last;
  addr_t         tail_inc;
  logic          overwrite;
  logic          do_write;

  lap_ring_ptr #(
    .RAM_ADDR_BITS(RAM_ADDR_BITS)
  ) u_ring (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .push     (lap_strobe),
    .head     (head),
    .tail     (tail),
    .count    (lap_count),
    .full     (full),
    .empty    (empty),
    .overflow (overflow),
    .overwrite(overwrite)
  );

  assign do_write  = lap_strobe && !clear;
  assign head_last = head - addr_t'(1);
  assign tail_inc  = addr_t'(mod_inc(32'(tail), RAM_ADDR_BITS));
  assign busy      = (state != ST_IDLE);

  // Cursor wraps back to the oldest entry after the newest, and is dragged
  // along when an overwrite retires the entry it points at.
  always_comb begin
    cursor_next = cursor;
    if (state == ST_WAIT) begin
      cursor_next = (cursor == head_last) ? tail
                                          : addr_t'(mod_inc(32'(cursor), RAM_ADDR_BITS));
    end
    if (overwrite && (cursor_next == tail)) begin
      cursor_next = tail_inc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_enable <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
    end else begin
      write_enable <= do_write;
      if (do_write) begin
        wr_addr <= head;
        wr_data <= lap_time;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cursor     <= '0;
      rd_addr    <= '0;
      disp_addr  <= '0;
      disp_data  <= '0;
      disp_valid <= 1'b0;
    end else if (clear) begin
      state      <= ST_IDLE;
      cursor     <= '0;
      disp_valid <= 1'b0;
    end else begin
      disp_valid <= 1'b0;
      cursor     <= cursor_next;
      case (state)
        ST_IDLE: begin
          if (recall_next && !empty) begin
            rd_addr   <= cursor;
            disp_addr <= cursor;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT: begin
          disp_data  <= rd_data;
          disp_valid <= 1'b1;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lap_log_ctrl.sv
// Bench for lap_log_ctrl with a read-first lap memory model behind it (DEPTH 4).
module tb_lap_log_ctrl;
  localparam int W  = 16;
  localparam int AB = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          lap_strobe;
  logic [W-1:0]  lap_time;
  logic          clear;
  logic          recall_next;
  logic [AB-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic          write_enable;
  logic [AB-1:0] rd_addr;
  logic [W-1:0]  rd_data;
  logic [W-1:0]  disp_data;
  logic [AB-1:0] disp_addr;
  logic          disp_valid;
  logic          busy;
  logic [AB:0]   lap_count;
  logic          empty;
  logic          full;
  logic          overflow;

  logic [W-1:0]      mem [0:3];
  logic [AB+W-1:0]   sb [$];
  logic [AB+W-1:0]   exp_entry;
  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (write_enable) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

  lap_log_ctrl #(.RAM_WIDTH(W), .RAM_ADDR_BITS(AB)) dut (
    .clk(clk), .rst(rst), .lap_strobe(lap_strobe), .lap_time(lap_time),
    .clear(clear), .recall_next(recall_next), .wr_addr(wr_addr),
    .wr_data(wr_data), .write_enable(write_enable), .rd_addr(rd_addr),
    .rd_data(rd_data), .disp_data(disp_data), .disp_addr(disp_addr),
    .disp_valid(disp_valid), .busy(busy), .lap_count(lap_count),
    .empty(empty), .full(full), .overflow(overflow)
  );

  task automatic test_reset();
    compared++;
    if ({write_enable, disp_valid, busy, empty, full, overflow} !== 6'b000100) begin
      mismatched++;
      $display("FAIL reset_flags: got %b want 000100",
               {write_enable, disp_valid, busy, empty, full, overflow});
    end
    compared++;
    if ({wr_addr, rd_addr, disp_addr, lap_count, wr_data, disp_data} !== '0) begin
      mismatched++;
      $display("FAIL reset_values: got %h want 0",
               {wr_addr, rd_addr, disp_addr, lap_count, wr_data, disp_data});
    end
  endtask

  task automatic strobe_once(input logic [W-1:0] v, input logic [AB-1:0] a);
    lap_strobe = 1'b1;
    lap_time   = v;
    @(negedge clk);
    lap_strobe = 1'b0;
    compared++;
    if ({write_enable, wr_addr, wr_data} !== {1'b1, a, v}) begin
      mismatched++;
      $display("FAIL write: got %h want %h", {write_enable, wr_addr, wr_data}, {1'b1, a, v});
    end
  endtask

  task automatic recall_expect();
    recall_next = 1'b1;
    @(negedge clk);
    recall_next = 1'b0;
    compared++;
    if ({busy, disp_valid} !== 2'b10) begin
      mismatched++;
      $display("FAIL recall_k0: busy/valid got %b want 10", {busy, disp_valid});
    end
    @(negedge clk);
    compared++;
    if ({busy, disp_valid} !== 2'b10) begin
      mismatched++;
      $display("FAIL recall_k1: busy/valid got %b want 10", {busy, disp_valid});
    end
    @(negedge clk);
    exp_entry = (sb.size() > 0) ? sb.pop_front() : '1;
    compared++;
    if ({busy, disp_valid, disp_addr, disp_data} !== {2'b01, exp_entry}) begin
      mismatched++;
      $display("FAIL recall_data: got %h want %h",
               {busy, disp_valid, disp_addr, disp_data}, {2'b01, exp_entry});
    end
    @(negedge clk);
    compared++;
    if (disp_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL recall_pulse: disp_valid got %b want 0", disp_valid);
    end
  endtask

  task automatic test_write();
    strobe_once(16'h0011, 2'd0);
    strobe_once(16'h0022, 2'd1);
    strobe_once(16'h0033, 2'd2);
    compared++;
    if ({lap_count, empty, full, overflow} !== {3'd3, 3'b000}) begin
      mismatched++;
      $display("FAIL write_status: got %h want %h",
               {lap_count, empty, full, overflow}, {3'd3, 3'b000});
    end
  endtask

  task automatic test_replay();
    sb.push_back({2'd0, 16'h0011});
    sb.push_back({2'd1, 16'h0022});
    sb.push_back({2'd2, 16'h0033});
    sb.push_back({2'd0, 16'h0011});
    for (int i = 0; i < 4; i++) recall_expect();
  endtask

  task automatic test_back_to_back_overflow();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    for (int i = 0; i < 6; i++) begin
      lap_strobe = 1'b1;
      lap_time   = W'(i + 1);
      @(negedge clk);
      compared++;
      if ({write_enable, wr_addr, wr_data} !== {1'b1, AB'(i), W'(i + 1)}) begin
        mismatched++;
        $display("FAIL b2b_write%0d: got %h want %h", i,
                 {write_enable, wr_addr, wr_data}, {1'b1, AB'(i), W'(i + 1)});
      end
    end
    lap_strobe = 1'b0;
    compared++;
    if ({lap_count, empty, full, overflow} !== {3'd4, 3'b011}) begin
      mismatched++;
      $display("FAIL overflow_status: got %h want %h",
               {lap_count, empty, full, overflow}, {3'd4, 3'b011});
    end
    sb.push_back({2'd2, 16'h0003});
    sb.push_back({2'd3, 16'h0004});
    sb.push_back({2'd0, 16'h0005});
    sb.push_back({2'd1, 16'h0006});
    for (int i = 0; i < 4; i++) recall_expect();
  endtask

  task automatic test_clear_with_strobe();
    clear      = 1'b1;
    lap_strobe = 1'b1;
    lap_time   = 16'hBEEF;
    @(negedge clk);
    clear      = 1'b0;
    lap_strobe = 1'b0;
    compared++;
    if ({write_enable, lap_count, empty, full, overflow} !== {1'b0, 3'd0, 3'b100}) begin
      mismatched++;
      $display("FAIL clear_strobe: got %h want %h",
               {write_enable, lap_count, empty, full, overflow}, {1'b0, 3'd0, 3'b100});
    end
    @(negedge clk);
    compared++;
    if (write_enable !== 1'b0) begin
      mismatched++;
      $display("FAIL clear_strobe_we: got %b want 0", write_enable);
    end
  endtask

  task automatic test_recall_empty();
    recall_next = 1'b1;
    @(negedge clk);
    recall_next = 1'b0;
    for (int i = 0; i < 3; i++) begin
      compared++;
      if ({busy, disp_valid} !== 2'b00) begin
        mismatched++;
        $display("FAIL recall_empty%0d: busy/valid got %b want 00", i, {busy, disp_valid});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_recall_busy();
    strobe_once(16'h00AA, 2'd0);
    sb.push_back({2'd0, 16'h00AA});
    recall_next = 1'b1;
    @(negedge clk);
    compared++;
    if (busy !== 1'b1) begin
      mismatched++;
      $display("FAIL busy_k0: got %b want 1", busy);
    end
    @(negedge clk);
    @(negedge clk);
    recall_next = 1'b0;
    exp_entry = (sb.size() > 0) ? sb.pop_front() : '1;
    compared++;
    if ({disp_valid, disp_addr, disp_data} !== {1'b1, exp_entry}) begin
      mismatched++;
      $display("FAIL busy_data: got %h want %h",
               {disp_valid, disp_addr, disp_data}, {1'b1, exp_entry});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      compared++;
      if ({busy, disp_valid} !== 2'b00) begin
        mismatched++;
        $display("FAIL busy_drop%0d: busy/valid got %b want 00", i, {busy, disp_valid});
      end
    end
  endtask

  task automatic test_reset_mid_replay();
    recall_next = 1'b1;
    @(negedge clk);
    recall_next = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      compared++;
      if ({busy, disp_valid, empty} !== 3'b001) begin
        mismatched++;
        $display("FAIL rst_replay%0d: busy/valid/empty got %b want 001", i,
                 {busy, disp_valid, empty});
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst         = 1'b1;
    lap_strobe  = 1'b0;
    lap_time    = '0;
    clear       = 1'b0;
    recall_next = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_write();
    test_replay();
    test_back_to_back_overflow();
    test_clear_with_strobe();
    test_recall_empty();
    test_recall_busy();
    test_reset_mid_replay();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
